// File: rtl/cbchk_pkg.sv
// rtl/cbchk_pkg.sv - shared types and constants for the code-block stream checker
//
// Purpose : FSM state encoding, default code-block sizes and the legal
//           reference-ROM latency range used by cb_stream_checker.
// Ports   : none (package).
package cbchk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cbchk_state_e;

  localparam int CB_SIZE_L_DEF = 6144;
  localparam int CB_SIZE_S_DEF = 1056;

  localparam int REF_LAT_MIN = 1;
  localparam int REF_LAT_MAX = 4;

  function automatic bit ref_lat_legal(input int lat);
    return (lat >= REF_LAT_MIN) && (lat <= REF_LAT_MAX);
  endfunction

endpackage

// File: rtl/cbchk_delay.sv
// rtl/cbchk_delay.sv - REF_LAT-deep {valid, data} delay line
//
// Purpose : Delays each received bit together with its valid tag so that it
//           lines up with the reference bit coming back from the ROM.
// Ports   : clk, reset (async, active-high), clr (sync clear),
//           shift_valid/shift_data (stage-0 input),
//           tap_valid/tap_data (output after DEPTH cycles).
module cbchk_delay
  import cbchk_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift_valid,
  input  logic shift_data,
  output logic tap_valid,
  output logic tap_data
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] data_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      data_sr  <= '0;
    end else if (clr) begin
      valid_sr <= '0;
      data_sr  <= '0;
    end else begin
      // Concatenate then truncate so a depth of 1 needs no special case.
      valid_sr <= DEPTH'({valid_sr, shift_valid});
      data_sr  <= DEPTH'({data_sr, shift_data});
    end
  end

  assign tap_valid = valid_sr[DEPTH-1];
  assign tap_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/cb_stream_checker.sv
// rtl/cb_stream_checker.sv - self-checking receiver for segmented code blocks
//
// Purpose : Receives serial code blocks, fetches the expected bits from an
//           external reference ROM, compares bit by bit and reports the
//           result over EXP_BLOCKS blocks.
// Ports   : clk, reset (async, active-high), clr (sync test restart)
//           start/cb_size/cb_data   - block stream from the segmenter
//           ref_addr/ref_sel        - reference ROM request
//           ref_data                - reference bit, REF_LAT cycles later
//           test_good/test_end      - registered verdict and completion pulse
//           err_count/blk_count     - mismatched bits (saturating) / blocks
//           proto_err               - sticky protocol-error flag
//           busy                    - block in RUN or DRAIN
// Options : CBCHK_TIMEOUT_EN enables the inter-block watchdog.
module cb_stream_checker
  import cbchk_pkg::*;
#(
  parameter int SIZE_L      = CB_SIZE_L_DEF,
  parameter int SIZE_S      = CB_SIZE_S_DEF,
  parameter int ADDR_W      = 13,
  parameter int REF_LAT     = 2,
  parameter int EXP_BLOCKS  = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              start,
  input  logic              cb_size,
  input  logic              cb_data,
  output logic [ADDR_W-1:0] ref_addr,
  output logic              ref_sel,
  input  logic              ref_data,
  output logic              test_good,
  output logic              test_end,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  blk_count,
  output logic              proto_err,
  output logic              busy
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  if (!ref_lat_legal(REF_LAT) || ((2 ** ADDR_W) < SIZE_L) || (SIZE_S < 1) ||
      (SIZE_S > SIZE_L) || (EXP_BLOCKS < 1) || (TIMEOUT_CYC < 1)) begin : g_cfg_check
    $error("cb_stream_checker: illegal parameter set");
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] last_addr;   // len-1 of the block in progress
  logic [2:0]        drain_cnt;
  logic              ended;       // test_end already fired since clr/reset

  logic              tap_valid;
  logic              tap_data;
  logic              mismatch;
  logic              proto_hit;
  logic              wd_fire;
  logic [CNT_W-1:0]  blk_inc;
  logic              reach_exp;

  cbchk_delay #(
    .DEPTH (REF_LAT)
  ) u_delay (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .shift_valid (state == RUN),
    .shift_data  (cb_data),
    .tap_valid   (tap_valid),
    .tap_data    (tap_data)
  );

  assign mismatch  = tap_valid && (tap_data != ref_data);
  assign proto_hit = start && ((state == RUN) || (state == DRAIN));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign blk_inc   = blk_count + CNT_W'(1);
  assign reach_exp = (blk_inc == CNT_W'(EXP_BLOCKS)) && !ended;

`ifdef CBCHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_count;
  logic            wd_armed;

  // Only the gap between blocks of a test is watched: nothing before the
  // first block, nothing once the expected count is met or the test ended.
  assign wd_armed = (state == IDLE) && (blk_count != '0) &&
                    (blk_count < CNT_W'(EXP_BLOCKS)) && !ended;
  assign wd_fire  = wd_armed && !start && (wd_count == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_count <= '0;
    end else if (clr || start || !wd_armed) begin
      wd_count <= '0;
    end else if (!wd_fire) begin
      wd_count <= wd_count + WD_W'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ref_addr  <= '0;
      ref_sel   <= 1'b0;
      last_addr <= '0;
      drain_cnt <= '0;
      ended     <= 1'b0;
      test_good <= 1'b1;
      test_end  <= 1'b0;
      err_count <= '0;
      blk_count <= '0;
      proto_err <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      ref_addr  <= '0;
      ref_sel   <= 1'b0;
      last_addr <= '0;
      drain_cnt <= '0;
      ended     <= 1'b0;
      test_good <= 1'b1;
      test_end  <= 1'b0;
      err_count <= '0;
      blk_count <= '0;
      proto_err <= 1'b0;
    end else begin
      test_end <= 1'b0;

      if (mismatch) begin
        test_good <= 1'b0;
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
      end

      if (proto_hit || wd_fire) begin
        proto_err <= 1'b1;
        test_good <= 1'b0;
      end

      case (state)
        // A start in the one-cycle DONE slot is taken as a new block rather
        // than dropped, so a block following test_end closely is not lost.
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            ref_sel   <= cb_size;
            ref_addr  <= '0;
            last_addr <= cb_size ? ADDR_W'(SIZE_L - 1) : ADDR_W'(SIZE_S - 1);
          end else if (wd_fire) begin
            state    <= DONE;
            test_end <= 1'b1;
            ended    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (ref_addr == last_addr) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            ref_addr <= ref_addr + ADDR_W'(1);
          end
        end

        // The last REF_LAT bits are still in the delay line; wait for them.
        DRAIN: begin
          if (drain_cnt == 3'(REF_LAT - 1)) begin
            if (blk_count != '1) begin
              blk_count <= blk_inc;
            end
            if (reach_exp) begin
              state    <= DONE;
              test_end <= 1'b1;
              ended    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
